// File: rtl/f2f_pkg.sv
// Shared types and float field layout for the fixed-to-float share arbiter.
// N_CH of the top level must match F2F_N_CH so that CH_W sizes the channel tag correctly.
package f2f_pkg;

    localparam int F2F_N_CH      = 4;
    localparam int CH_W          = $clog2(F2F_N_CH);

    localparam int FLT_SIGN_BIT  = 31;
    localparam int FLT_EXP_LSB   = 23;
    localparam int FLT_EXP_W     = 8;
    localparam int FLT_MAN_LSB   = 0;
    localparam int FLT_MAN_W     = 23;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } f2f_tag_t;

    function automatic logic [31:0] f2f_pack(input logic s,
                                             input logic [FLT_EXP_W-1:0] e,
                                             input logic [FLT_MAN_W-1:0] m);
        logic [31:0] r;
        r = '0;
        r[FLT_SIGN_BIT] = s;
        r[FLT_EXP_LSB +: FLT_EXP_W] = e;
        r[FLT_MAN_LSB +: FLT_MAN_W] = m;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO with occupancy count.
// The head entry is visible on pop_data_o whenever count_o is non-zero.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Upstream credit accounting must make overflow unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push_i) begin
            assert (count_q != CNT_W'(DEPTH));
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/f2f_share_arbiter.sv
// Round-robin sharing of one non-stallable fixed-to-float converter among N_CH requesters.
// Channel tags ride a delay line matched to the converter; credits keep the result FIFO from overflowing.
module f2f_share_arbiter
    import f2f_pkg::*;
#(
    parameter int N_CH        = F2F_N_CH,
    parameter int FIXED_WIDTH = 12,
    parameter int FLOAT_WIDTH = 32,
    parameter int CVT_LAT     = 4,
    parameter int DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               req_valid,
    input  logic [N_CH*FIXED_WIDTH-1:0]   req_data,
    output logic [N_CH-1:0]               req_ready,
    output logic [FIXED_WIDTH-1:0]        cvt_a,
    input  logic [FLOAT_WIDTH-1:0]        cvt_q,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [FLOAT_WIDTH-1:0]        res_data,
    output logic [CH_W-1:0]               res_ch,
    output logic                          busy
);

    localparam int CR_W  = $clog2(DEPTH + 1);
    localparam int FF_W  = FLOAT_WIDTH + CH_W;

    logic [CR_W-1:0]        credits_q, credits_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [FIXED_WIDTH-1:0] cvt_a_q, cvt_a_d;
    f2f_tag_t               tag_q [CVT_LAT+1];
    f2f_tag_t               tag_d;

    logic                   found;
    logic [CH_W-1:0]        winner;
    int                     scan_idx;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   any_tag;
    int                     inflight;

    logic [FF_W-1:0]        fifo_head;
    logic                   fifo_empty;
    logic [CR_W-1:0]        fifo_cnt;

    // Scan starts one past the last winner so every channel gets a turn.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 1; k <= N_CH; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_CH;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = CH_W'(scan_idx);
            end
        end
    end

    always_comb begin
        issue     = rst_n && (credits_q != '0) && found;
        req_ready = issue ? (N_CH'(1) << winner) : '0;
        push      = tag_q[CVT_LAT].valid;
        pop       = res_valid && res_ready;
        credits_d = credits_q - CR_W'(issue) + CR_W'(pop);
        rr_ptr_d  = issue ? winner : rr_ptr_q;
        cvt_a_d   = issue ? req_data[winner*FIXED_WIDTH +: FIXED_WIDTH] : '0;
        tag_d     = '{valid: issue, ch: winner};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q <= CR_W'(DEPTH);
            rr_ptr_q  <= CH_W'(N_CH - 1);
            cvt_a_q   <= '0;
            for (int i = 0; i <= CVT_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            credits_q <= credits_d;
            rr_ptr_q  <= rr_ptr_d;
            cvt_a_q   <= cvt_a_d;
            tag_q[0]  <= tag_d;
            for (int i = 1; i <= CVT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        any_tag  = 1'b0;
        inflight = 0;
        for (int i = 0; i <= CVT_LAT; i++) begin
            any_tag  = any_tag | tag_q[i].valid;
            inflight = inflight + int'(tag_q[i].valid);
        end
    end

    // Every credit is either spare, riding the tag line, or parked in the FIFO.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (int'(credits_q) + inflight + int'(fifo_cnt) == DEPTH);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (FF_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({cvt_q, tag_q[CVT_LAT].ch}),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign cvt_a     = cvt_a_q;
    assign res_valid = !fifo_empty;
    assign res_data  = fifo_head[FF_W-1:CH_W];
    assign res_ch    = fifo_head[CH_W-1:0];
    assign busy      = any_tag || (fifo_cnt != '0);

endmodule

// File: tb/tb_f2f_share_arbiter.sv
// Bench for f2f_share_arbiter: ideal delayed converter model, grant/credit model and result scoreboard.
module tb_f2f_share_arbiter;
    import f2f_pkg::*;

    localparam int N_CH    = 4;
    localparam int FW      = 12;
    localparam int FLW     = 32;
    localparam int CVT_LAT = 4;
    localparam int DEPTH   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      req_valid;
    logic [N_CH*FW-1:0]   req_data;
    logic [N_CH-1:0]      req_ready;
    logic [FW-1:0]        cvt_a;
    logic [FLW-1:0]       cvt_q;
    logic                 res_valid;
    logic                 res_ready;
    logic [FLW-1:0]       res_data;
    logic [CH_W-1:0]      res_ch;
    logic                 busy;

    always #5 clk = ~clk;

    f2f_share_arbiter #(
        .N_CH(N_CH), .FIXED_WIDTH(FW), .FLOAT_WIDTH(FLW), .CVT_LAT(CVT_LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cvt_a(cvt_a), .cvt_q(cvt_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
        .busy(busy)
    );

    // Ideal signed-integer to IEEE single conversion.
    function automatic logic [31:0] conv(input logic [FW-1:0] x);
        int v;
        int m;
        int p;
        logic [31:0] man;
        v = int'($signed(x));
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 13; i++) if (m[i]) p = i;
        man = (32'(m) << (23 - p)) & 32'h007F_FFFF;
        return {(v < 0), 8'(127 + p), man[22:0]};
    endfunction

    logic [FW-1:0] dly [CVT_LAT];
    always @(posedge clk) begin
        dly[0] <= cvt_a;
        for (int i = 1; i < CVT_LAT; i++) dly[i] <= dly[i-1];
    end
    assign cvt_q = conv(dly[CVT_LAT-1]);

    typedef struct {
        logic [31:0]     d;
        logic [CH_W-1:0] ch;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [N_CH-1:0] v;
        logic [N_CH-1:0] exp;
    } vec_t;
    vec_t tbl[10];

    int              checks = 0;
    int              failures = 0;
    logic [CH_W-1:0] mdl_rr;
    logic            hold_v;
    logic [63:0]     hold_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N_CH-1:0] mdl_grant(input logic [CH_W-1:0] rr, input logic [N_CH-1:0] v);
        for (int k = 1; k <= N_CH; k++) begin
            int idx;
            idx = (int'(rr) + k) % N_CH;
            if (v[idx]) return N_CH'(1) << idx;
        end
        return '0;
    endfunction

    // Mid-cycle sample: grant model, hold stability, scoreboard pop then push.
    task automatic sample();
        logic [N_CH-1:0] eg;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'h0);
            sbq.delete();
            mdl_rr = CH_W'(N_CH - 1);
            hold_v = 1'b0;
            return;
        end
        eg = (sbq.size() < DEPTH) ? mdl_grant(mdl_rr, req_valid) : '0;
        chk("grant", 64'(req_ready), 64'(eg));
        if (hold_v) begin
            chk("hold_valid", 64'(res_valid), 64'h1);
            chk("hold_data", {30'h0, res_ch, res_data}, hold_val);
        end
        if (res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got data %0h ch %0d expected none", res_data, res_ch);
            end else begin
                e = sbq.pop_front();
                chk("res_data", 64'(res_data), 64'(e.d));
                chk("res_ch", 64'(res_ch), 64'(e.ch));
            end
        end
        if (eg != '0) begin
            for (int w = 0; w < N_CH; w++) begin
                if (eg[w]) begin
                    e.d  = conv(req_data[w*FW +: FW]);
                    e.ch = CH_W'(w);
                    sbq.push_back(e);
                    mdl_rr = CH_W'(w);
                end
            end
        end
        hold_v   = res_valid && !res_ready;
        hold_val = {30'h0, res_ch, res_data};
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        res_ready = 1'b1;
        forever begin
            sample();
            if (sbq.size() == 0 && !res_valid) break;
            n++;
            if (n >= 60) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
                break;
            end
            next();
        end
        chk("drain_busy", 64'(busy), 64'h0);
        next();
    endtask

    task automatic single(input int ch, input logic [FW-1:0] data, input logic [31:0] expf);
        req_valid = N_CH'(1) << ch;
        req_data = '0;
        req_data[ch*FW +: FW] = data;
        sample();
        chk("single_grant", 64'(req_ready), 64'(N_CH'(1) << ch));
        next();
        req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            sample();
            if (c == 1) chk("cvt_a_data", 64'(cvt_a), 64'(data));
            if (c == 2) chk("cvt_a_idle", 64'(cvt_a), 64'h0);
            if (c < 6) begin
                chk("latency_early", 64'(res_valid), 64'h0);
            end else begin
                chk("latency_valid", 64'(res_valid), 64'h1);
                chk("single_data", 64'(res_data), 64'(expf));
                chk("single_ch", 64'(res_ch), 64'(ch));
            end
            next();
        end
    endtask

    initial begin
        int hs;
        int vcnt;
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b0101, 4'b0100};
        tbl[3] = '{4'b0101, 4'b0001};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b0000, 4'b0000};
        tbl[6] = '{4'b0110, 4'b0010};
        tbl[7] = '{4'b0011, 4'b0001};
        tbl[8] = '{4'b1111, 4'b0010};
        tbl[9] = '{4'b1001, 4'b1000};

        rst_n = 1'b0;
        req_valid = '1;
        req_data = '0;
        res_ready = 1'b1;
        mdl_rr = CH_W'(N_CH - 1);
        hold_v = 1'b0;
        hold_val = '0;

        repeat (3) begin
            sample();
            next();
        end
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;

        // Arbitration vectors straight out of reset.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v;
            req_data = 48'({$urandom(), $urandom()});
            sample();
            chk("tbl_grant", 64'(req_ready), 64'(tbl[i].exp));
            if (i == 0) begin
                chk("first_res_valid", 64'(res_valid), 64'h0);
                chk("first_busy", 64'(busy), 64'h0);
            end
            next();
        end
        drain();

        single(2, 12'h001, 32'h3F80_0000);
        drain();
        single(2, 12'hFFE, 32'hC000_0000);
        drain();
        single(2, 12'h000, 32'h0000_0000);
        drain();

        // All channels requesting with a free-running consumer.
        res_ready = 1'b1;
        req_valid = '1;
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            if (c >= 8 && res_valid) vcnt++;
            next();
        end
        chk("throughput", 64'(vcnt), 64'd32);
        drain();

        // Stalled consumer: credits cap the handshakes at DEPTH.
        res_ready = 1'b0;
        req_valid = '1;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            if (req_ready != '0) hs++;
            next();
        end
        chk("bp_handshakes", 64'(hs), 64'd8);
        res_ready = 1'b1;
        sample();
        chk("bp_pop_no_issue", 64'(req_ready), 64'h0);
        next();
        sample();
        chk("bp_issue_after_pop", 64'(req_ready != '0), 64'h1);
        next();
        for (int c = 0; c < 20; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            next();
        end
        drain();

        // Credits at one and zero with a pop in the same cycle.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            next();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            sample();
            next();
        end
        req_valid = 4'b0001;
        res_ready = 1'b1;
        sample();
        chk("cr1_pop_issue", 64'(req_ready), 64'h1);
        next();
        res_ready = 1'b0;
        sample();
        chk("cr1_kept", 64'(req_ready), 64'h1);
        next();
        res_ready = 1'b1;
        sample();
        chk("cr0_pop_no_issue", 64'(req_ready), 64'h0);
        next();
        res_ready = 1'b0;
        sample();
        chk("cr0_issue_next", 64'(req_ready), 64'h1);
        next();
        drain();

        // Reset with two results queued and three conversions in flight.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            next();
        end
        req_valid = '0;
        for (int c = 0; c < 7; c++) begin
            sample();
            next();
        end
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            next();
        end
        req_valid = '0;
        rst_n = 1'b0;
        sample();
        next();
        rst_n = 1'b1;
        req_valid = '1;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            req_data = 48'({$urandom(), $urandom()});
            sample();
            if (c == 0) begin
                chk("post_rst_grant", 64'(req_ready), 64'h1);
                chk("post_rst_busy", 64'(busy), 64'h0);
            end
            if (c < 6) chk("post_rst_res_valid", 64'(res_valid), 64'h0);
            if (req_ready != '0) hs++;
            next();
        end
        chk("post_rst_credits", 64'(hs), 64'd8);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
